// File: rtl/rr_merge_4.sv
// rr_merge_4 -- four-channel round-robin stream merger.
//
// Gathers beats from four valid/ready source channels onto one registered
// output channel and tags each output beat with its source index (SEL).
// The rotating priority pointer starts the search at the channel after the
// last winner, so continuously valid channels are served 0,1,2,3,0,...
// Idle channels are skipped.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   D0..D3, V0..V3  source channel data / valid
//   R0..R3          source channel ready (at most one high per cycle)
//   Y, SEL, VY      registered output data, source index, valid
//   RY              downstream ready
//
// Optional feature, macro RR_MERGE_LOCK_EN:
//   L0..L3          last-beat-of-packet flag per channel
//   YL              registered last flag of the current output beat
//   A channel that starts a packet keeps exclusive ownership of the output
//   until its last beat; the pointer advances only on that last beat.
module rr_merge_4 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic             V0,
  input  logic             V1,
  input  logic             V2,
  input  logic             V3,
  output logic             R0,
  output logic             R1,
  output logic             R2,
  output logic             R3,
  output logic [WIDTH-1:0] Y,
  output logic [1:0]       SEL,
  output logic             VY,
  input  logic             RY
`ifdef RR_MERGE_LOCK_EN
  ,
  input  logic             L0,
  input  logic             L1,
  input  logic             L2,
  input  logic             L3,
  output logic             YL
`endif
);

  localparam int NUM_CH = 4;

  // Occupancy state of the output register.
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [NUM_CH-1:0][WIDTH-1:0] d_in;
  logic [NUM_CH-1:0]            v_in;
  logic [NUM_CH-1:0]            req;     // valid after lock masking
  logic [NUM_CH-1:0]            gnt_oh;
  logic [NUM_CH-1:0]            rdy;
  logic [NUM_CH-1:0][1:0]       idx;     // search order starting at ptr_q

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [WIDTH-1:0] y_q,     y_d;
  logic [1:0]       sel_q,   sel_d;

  logic       ld;
  logic       found;
  logic [1:0] gnt;
  logic       advance;

  assign d_in = {D3, D2, D1, D0};
  assign v_in = {V3, V2, V1, V0};

  // Load whenever the output register is empty or is being drained this edge,
  // which gives simultaneous consume + refill with no bubble.
  assign ld = (state_q == S_EMPTY) || RY;

`ifdef RR_MERGE_LOCK_EN
  logic [NUM_CH-1:0] l_in;
  logic              lock_q,    lock_d;
  logic [1:0]        lock_ch_q, lock_ch_d;
  logic              yl_q,      yl_d;
  logic              lg;

  assign l_in = {L3, L2, L1, L0};
  assign lg   = l_in[gnt];

  // While a packet is open only its owner may request.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_req
    assign req[i] = v_in[i] && (!lock_q || (lock_ch_q == 2'(i)));
  end

  // Mid-packet beats keep the pointer so the packet owner stays first.
  assign advance = lg;
`else
  assign req     = v_in;
  assign advance = 1'b1;
`endif

  // Rotated search order: idx[k] = ptr_q + k (mod 4).
  for (genvar k = 0; k < NUM_CH; k++) begin : g_idx
    assign idx[k] = ptr_q + 2'(k);
  end

  // First requester at or after ptr_q wins. Depends only on valids and
  // pointer/lock state, never on channel data.
  always_comb begin
    found = 1'b0;
    gnt   = ptr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[idx[k]]) begin
        found = 1'b1;
        gnt   = idx[k];
      end
    end
  end

  // Per-channel ready. RST_N gates it so no beat is handed off while the
  // block is held in reset.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign gnt_oh[i] = found && (gnt == 2'(i));
    assign rdy[i]    = RST_N && ld && gnt_oh[i];
  end

  assign R0 = rdy[0];
  assign R1 = rdy[1];
  assign R2 = rdy[2];
  assign R3 = rdy[3];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    sel_d   = sel_q;
    if (ld) begin
      if (found) begin
        y_d     = d_in[gnt];
        sel_d   = gnt;
        state_d = S_FULL;
        if (advance) ptr_d = gnt + 2'd1;
      end else begin
        // Drained with nothing to refill: data and tag hold, valid drops.
        state_d = S_EMPTY;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_EMPTY;
      ptr_q   <= 2'd0;
      y_q     <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
    end
  end

`ifdef RR_MERGE_LOCK_EN
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    yl_d      = yl_q;
    if (ld && found) begin
      lock_d    = !lg;
      lock_ch_d = gnt;
      yl_d      = lg;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_q    <= 1'b0;
      lock_ch_q <= 2'd0;
      yl_q      <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      yl_q      <= yl_d;
    end
  end

  assign YL = yl_q;
`endif

  assign Y   = y_q;
  assign SEL = sel_q;
  assign VY  = (state_q == S_FULL);

endmodule

// File: tb/tb_rr_merge_4.sv
// Directed bench for rr_merge_4: reset, single source, skip/wrap, fair
// rotation, backpressure, reset mid-transfer and (with RR_MERGE_LOCK_EN)
// packet locking.
module tb_rr_merge_4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] D0, D1, D2, D3;
  logic       V0, V1, V2, V3;
  logic       R0, R1, R2, R3;
  logic [7:0] Y;
  logic [1:0] SEL;
  logic       VY;
  logic       RY;
`ifdef RR_MERGE_LOCK_EN
  logic       L0, L1, L2, L3;
  logic       YL;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  rr_merge_4 #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .V0(V0), .V1(V1), .V2(V2), .V3(V3),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .Y(Y), .SEL(SEL), .VY(VY), .RY(RY)
`ifdef RR_MERGE_LOCK_EN
    , .L0(L0), .L1(L1), .L2(L2), .L3(L3), .YL(YL)
`endif
  );

  always #5 CLK = ~CLK;

  wire [3:0] rv = {R3, R2, R1, R0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setv(input logic [3:0] v);
    {V3, V2, V1, V0} = v;
  endtask

  task automatic out(input string tag, input logic [7:0] y, input logic [1:0] s, input logic v);
    chk({tag, "_Y"},   32'(Y),   32'(y));
    chk({tag, "_SEL"}, 32'(SEL), 32'(s));
    chk({tag, "_VY"},  32'(VY),  32'(v));
  endtask

  initial begin
    RST_N = 1'b0; RY = 1'b0;
    D0 = 8'h00; D1 = 8'h00; D2 = 8'h00; D3 = 8'h00;
    setv(4'b1111);
`ifdef RR_MERGE_LOCK_EN
    L0 = 1'b1; L1 = 1'b1; L2 = 1'b1; L3 = 1'b1;
`endif
    #2;
    out("rst", 8'h00, 2'd0, 1'b0);
    chk("rst_R", 32'(rv), 32'h0);
    tick();
    RST_N = 1'b1;

    // Single source on channel 2.
    setv(4'b0100); D2 = 8'h5A; RY = 1'b1;
    #1 chk("single_R", 32'(rv), 32'b0100);
    tick();
    out("single", 8'h5A, 2'd2, 1'b1);

    // Pointer now 3: channel 3 beats channel 0.
    setv(4'b1001); D0 = 8'hA0; D3 = 8'hA3;
    #1 chk("ptr3_R", 32'(rv), 32'b1000);
    tick();
    out("ptr3", 8'hA3, 2'd3, 1'b1);
    setv(4'b0001);
    #1 chk("ptr0_R", 32'(rv), 32'b0001);
    tick();
    out("ptr0", 8'hA0, 2'd0, 1'b1);

    // Skip and wrap from pointer 1: grants 3 then 0.
    setv(4'b1001); D0 = 8'hB0; D3 = 8'hB3;
    #1 chk("skip_R", 32'(rv), 32'b1000);
    tick();
    out("skip3", 8'hB3, 2'd3, 1'b1);
    setv(4'b0001);
    #1 chk("wrap_R", 32'(rv), 32'b0001);
    tick();
    out("wrap0", 8'hB0, 2'd0, 1'b1);

    // Nothing valid: output drains, Y and SEL hold.
    setv(4'b0000);
    tick();
    out("drain", 8'hB0, 2'd0, 1'b0);

    // Pointer is 1; one beat from channel 3 brings it to 0.
    setv(4'b1000); D3 = 8'h77;
    tick();
    out("pre", 8'h77, 2'd3, 1'b1);

    // All four valid: fair rotation 0,1,2,3,0.
    setv(4'b1111); D0 = 8'h10; D1 = 8'h11; D2 = 8'h12; D3 = 8'h13;
    #1 chk("rr_R", 32'(rv), 32'b0001);
    tick(); out("rr0", 8'h10, 2'd0, 1'b1);
    tick(); out("rr1", 8'h11, 2'd1, 1'b1);
    tick(); out("rr2", 8'h12, 2'd2, 1'b1);
    tick(); out("rr3", 8'h13, 2'd3, 1'b1);
    tick(); out("rr4", 8'h10, 2'd0, 1'b1);
    tick(); out("bp_load", 8'h11, 2'd1, 1'b1);

    // Backpressure: hold for three cycles, no readies.
    RY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_R", 32'(rv), 32'h0);
      tick();
      out("bp_hold", 8'h11, 2'd1, 1'b1);
    end
    RY = 1'b1;
    #1 chk("bp_rel_R", 32'(rv), 32'b0100);
    tick();
    out("bp_nobubble", 8'h12, 2'd2, 1'b1);

    // Reset mid-transfer: immediate clear, pointer back to 0.
    #2 RST_N = 1'b0;
    #1;
    out("mrst", 8'h00, 2'd0, 1'b0);
    chk("mrst_R", 32'(rv), 32'h0);
    #1 RST_N = 1'b1;
    #1 chk("mrst_ptr_R", 32'(rv), 32'b0001);
    tick();
    out("mrst_first", 8'h10, 2'd0, 1'b1);

`ifdef RR_MERGE_LOCK_EN
    // Pointer is 1: channel 1 sends a 3-beat packet while 0 and 2 wait.
    setv(4'b0111); D1 = 8'h21; L1 = 1'b0;
    #1 chk("lk_R0", 32'(rv), 32'b0010);
    tick(); out("lk0", 8'h21, 2'd1, 1'b1); chk("lk0_YL", 32'(YL), 32'h0);
    D1 = 8'h22;
    #1 chk("lk_R1", 32'(rv), 32'b0010);
    tick(); out("lk1", 8'h22, 2'd1, 1'b1); chk("lk1_YL", 32'(YL), 32'h0);
    D1 = 8'h23; L1 = 1'b1;
    #1 chk("lk_R2", 32'(rv), 32'b0010);
    tick(); out("lk2", 8'h23, 2'd1, 1'b1); chk("lk2_YL", 32'(YL), 32'h1);
    setv(4'b0101);
    tick(); out("lk_next", 8'h12, 2'd2, 1'b1); chk("lk_next_YL", 32'(YL), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Whole run is a few dozen cycles; anything beyond this is a hang.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
